// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: seven-segment codes and BCD helpers shared by the display counter.
package bcd_disp_pkg;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG7_LUT [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    function automatic logic [7:0] seg7_decode(input logic [3:0] d);
        return (d < 4'd10) ? SEG7_LUT[d] : SEG_BLANK;
    endfunction

    // Elaboration-time conversion of a decimal terminal count into packed BCD.
    function automatic logic [31:0] int_to_bcd(input int value, input int n);
        logic [31:0] r;
        int          v;
        r = '0;
        v = value;
        for (int i = 0; i < 8; i++) begin
            if (i < n) r[4*i+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running divider giving a one-cycle tick every DIV clk_sys cycles.
module tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk_sys,
    input  logic rst,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = cnt_q == LAST;
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_sys or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: N-digit up/down BCD counter with a multiplexed
// common-cathode seven-segment scan driver and leading-zero blanking.
module bcd_scan_counter
    import bcd_disp_pkg::*;
#(
    parameter int N_DIGITS = 2,
    parameter int MAX_VAL  = 59,
    parameter int TICK_DIV = 25000000,
    parameter int SCAN_DIV = 25000
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  blank_lz,
    output logic [4*N_DIGITS-1:0] bcd,
    output logic                  carry,
    output logic [N_DIGITS-1:0]   seg,
    output logic [7:0]            Q
);
    localparam int BW = 4 * N_DIGITS;
    localparam logic [31:0]         MAX_BCD32 = int_to_bcd(MAX_VAL, N_DIGITS);
    localparam logic [BW-1:0]       MAX_BCD   = MAX_BCD32[BW-1:0];
    localparam logic [N_DIGITS-1:0] SEG_RST   = ~N_DIGITS'(1);

    logic                count_tick, scan_tick;
    logic [BW-1:0]       bcd_q, bcd_d, inc_v, dec_v;
    logic [N_DIGITS-1:0] seg_q, seg_d;
    logic                carry_q, carry_d;
    logic                at_max, at_zero, step;

    tick_gen #(.DIV(TICK_DIV)) u_count_tick (.clk_sys(clk_sys), .rst(rst), .tick(count_tick));
    tick_gen #(.DIV(SCAN_DIV)) u_scan_tick  (.clk_sys(clk_sys), .rst(rst), .tick(scan_tick));

    // A digit moves only while every lower digit is wrapping (9->0 up, 0->9 down).
    always_comb begin : ripple
        logic c, b;
        c     = 1'b1;
        b     = 1'b1;
        inc_v = bcd_q;
        dec_v = bcd_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            inc_v[4*i+:4] = c ? ((bcd_q[4*i+:4] == 4'd9) ? 4'd0 : bcd_q[4*i+:4] + 4'd1) : bcd_q[4*i+:4];
            dec_v[4*i+:4] = b ? ((bcd_q[4*i+:4] == 4'd0) ? 4'd9 : bcd_q[4*i+:4] - 4'd1) : bcd_q[4*i+:4];
            c = c & (bcd_q[4*i+:4] == 4'd9);
            b = b & (bcd_q[4*i+:4] == 4'd0);
        end
    end

    always_comb begin
        at_max  = bcd_q == MAX_BCD;
        at_zero = bcd_q == '0;
        step    = count_tick & en;
        bcd_d   = clr   ? '0 :
                  !step ? bcd_q :
                  up_dn ? (at_max ? '0 : inc_v) :
                          (at_zero ? MAX_BCD : dec_v);
        carry_d = !clr && step && (up_dn ? at_max : at_zero);
        seg_d   = scan_tick ? ((seg_q << 1) | (seg_q >> (N_DIGITS - 1))) : seg_q;
    end

    always_ff @(posedge clk_sys or posedge rst)
        if (rst) begin
            bcd_q   <= '0;
            carry_q <= 1'b0;
            seg_q   <= SEG_RST;
        end else begin
            bcd_q   <= bcd_d;
            carry_q <= carry_d;
            seg_q   <= seg_d;
        end

    // Walk from the top digit so hi_zero means "this digit and all above are zero".
    always_comb begin : display
        logic       hi_zero, lead_blank;
        logic [3:0] dig;
        hi_zero    = 1'b1;
        lead_blank = 1'b0;
        dig        = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            hi_zero = hi_zero & (bcd_q[4*i+:4] == 4'd0);
            if (!seg_q[i]) begin
                dig        = bcd_q[4*i+:4];
                lead_blank = hi_zero && (i > 0);
            end
        end
        Q = (!$onehot(~seg_q) || (blank_lz && lead_blank)) ? SEG_BLANK : seg7_decode(dig);
    end

    assign bcd   = bcd_q;
    assign carry = carry_q;
    assign seg   = seg_q;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: directed and randomized checks of two bcd_scan_counter
// configurations against a decimal-integer model of the count and display.
module tb_bcd_scan_counter;
    logic clk_sys = 1'b0, rst = 1'b1, en = 1'b0, up_dn = 1'b1, clr = 1'b0, blank_lz = 1'b0;
    logic [7:0]  bcd1, q1;
    logic [1:0]  seg1;
    logic        carry1;
    logic [11:0] bcd2;
    logic [7:0]  q2;
    logic [2:0]  seg2;
    logic        carry2;
    int checks = 0, errors = 0;
    int m_val[2], m_car[2], m_tcnt[2], m_scnt[2], m_sel[2];
    int seg7_tab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

    always #5 clk_sys = ~clk_sys;

    bcd_scan_counter #(.N_DIGITS(2), .MAX_VAL(59), .TICK_DIV(4), .SCAN_DIV(2)) dut1 (
        .clk_sys(clk_sys), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .blank_lz(blank_lz),
        .bcd(bcd1), .carry(carry1), .seg(seg1), .Q(q1));

    bcd_scan_counter #(.N_DIGITS(3), .MAX_VAL(999), .TICK_DIV(1), .SCAN_DIV(1)) dut2 (
        .clk_sys(clk_sys), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .blank_lz(blank_lz),
        .bcd(bcd2), .carry(carry2), .seg(seg2), .Q(q2));

    function automatic int nd(int k); return k ? 3 : 2; endfunction
    function automatic int mx(int k); return k ? 999 : 59; endfunction
    function automatic int td(int k); return k ? 1 : 4; endfunction
    function automatic int sd(int k); return k ? 1 : 2; endfunction

    function automatic int p10(int e);
        int r = 1;
        for (int i = 0; i < e; i++) r *= 10;
        return r;
    endfunction

    function automatic int to_bcd(int v);
        int r = 0;
        for (int i = 0; i < 8; i++) r += ((v / p10(i)) % 10) << (4 * i);
        return r;
    endfunction

    function automatic int exp_q(int k, logic bl);
        int d = (m_val[k] / p10(m_sel[k])) % 10;
        return (bl && m_sel[k] > 0 && m_val[k] < p10(m_sel[k])) ? 0 : seg7_tab[d];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Decimal model: count value, active digit index and divider phases as plain integers.
    always @(posedge clk_sys or posedge rst)
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_val[k] <= 0; m_car[k] <= 0; m_tcnt[k] <= 0; m_scnt[k] <= 0; m_sel[k] <= 0;
            end else begin
                automatic bit tk = m_tcnt[k] == td(k) - 1;
                automatic bit sk = m_scnt[k] == sd(k) - 1;
                m_tcnt[k] <= tk ? 0 : m_tcnt[k] + 1;
                m_scnt[k] <= sk ? 0 : m_scnt[k] + 1;
                if (sk) m_sel[k] <= (m_sel[k] + 1) % nd(k);
                if (clr) begin
                    m_val[k] <= 0; m_car[k] <= 0;
                end else if (tk && en && up_dn) begin
                    m_val[k] <= (m_val[k] == mx(k)) ? 0 : m_val[k] + 1;
                    m_car[k] <= int'(m_val[k] == mx(k));
                end else if (tk && en) begin
                    m_val[k] <= (m_val[k] == 0) ? mx(k) : m_val[k] - 1;
                    m_car[k] <= int'(m_val[k] == 0);
                end else m_car[k] <= 0;
            end
        end

    always begin
        @(posedge clk_sys);
        #2;
        if (!rst) begin
            chk("m_bcd1", 32'(bcd1), to_bcd(m_val[0]));
            chk("m_carry1", 32'(carry1), m_car[0]);
            chk("m_seg1", 32'(seg1), ~(1 << m_sel[0]) & 3);
            chk("m_q1", 32'(q1), exp_q(0, blank_lz));
            chk("m_bcd2", 32'(bcd2), to_bcd(m_val[1]));
            chk("m_carry2", 32'(carry2), m_car[1]);
            chk("m_seg2", 32'(seg2), ~(1 << m_sel[1]) & 7);
            chk("m_q2", 32'(q2), exp_q(1, blank_lz));
        end
    end

    task automatic go_to(input logic [7:0] t);
        int n = 0;
        while (bcd1 !== t && n < 2000) begin @(negedge clk_sys); n++; end
        chk("go_to", 32'(bcd1), 32'(t));
    endtask

    task automatic tick_expect(input string nm, input logic [7:0] e, input logic ec);
        logic [7:0] old = bcd1;
        int n = 0;
        while (bcd1 === old && n < 20) begin @(negedge clk_sys); n++; end
        chk(nm, 32'(bcd1), 32'(e));
        chk({nm, "_carry"}, 32'(carry1), 32'(ec));
    endtask

    task automatic wait_seg1(input logic [1:0] s);
        int n = 0;
        while (seg1 !== s && n < 20) begin @(negedge clk_sys); n++; end
        chk("wait_seg1", 32'(seg1), 32'(s));
    endtask

    task automatic release_and_first_tick(input string nm);
        @(negedge clk_sys);
        rst = 1'b0; en = 1'b1; up_dn = 1'b1; clr = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk({nm, "_pre"}, 32'(bcd1), 32'h00);
        @(negedge clk_sys);
        chk(nm, 32'(bcd1), 32'h01);
    endtask

    initial begin
        logic [1:0] prev;
        int n;
        repeat (3) @(negedge clk_sys);
        chk("rst_bcd", 32'(bcd1), 32'h00);
        chk("rst_seg", 32'(seg1), 32'h2);
        chk("rst_carry", 32'(carry1), 32'h0);
        chk("rst_q", 32'(q1), 32'h3F);
        chk("rst_seg2", 32'(seg2), 32'h6);
        release_and_first_tick("first_tick");

        go_to(8'h37);
        #2 rst = 1'b1;
        #1;
        chk("async_bcd", 32'(bcd1), 32'h00);
        chk("async_seg", 32'(seg1), 32'h2);
        chk("async_carry", 32'(carry1), 32'h0);
        release_and_first_tick("first_tick_again");

        go_to(8'h58);
        tick_expect("up_58_59", 8'h59, 1'b0);
        tick_expect("up_wrap", 8'h00, 1'b1);
        @(negedge clk_sys);
        chk("carry_pulse", 32'(carry1), 32'h0);
        go_to(8'h09);
        tick_expect("up_09_10", 8'h10, 1'b0);

        up_dn = 1'b0;
        tick_expect("dn_10_09", 8'h09, 1'b0);
        go_to(8'h00);
        tick_expect("dn_wrap", 8'h59, 1'b1);

        up_dn = 1'b1;
        go_to(8'h42);
        n = 0;
        while (m_tcnt[0] != 3 && n < 8) begin @(negedge clk_sys); n++; end
        clr = 1'b1;
        @(negedge clk_sys);
        clr = 1'b0;
        chk("clr_tick_bcd", 32'(bcd1), 32'h00);
        chk("clr_tick_carry", 32'(carry1), 32'h0);
        go_to(8'h23);
        en = 1'b0;
        repeat (12) @(negedge clk_sys);
        chk("en_hold", 32'(bcd1), 32'h23);

        n = 0;
        prev = seg1;
        while (!(prev == 2'b01 && seg1 == 2'b10) && n < 20) begin
            prev = seg1;
            @(negedge clk_sys);
            n++;
        end
        chk("scan_start", 32'(seg1), 32'h2);
        repeat (2) @(negedge clk_sys);
        chk("scan_01", 32'(seg1), 32'h1);
        repeat (2) @(negedge clk_sys);
        chk("scan_10", 32'(seg1), 32'h2);

        clr = 1'b1;
        @(negedge clk_sys);
        clr = 1'b0; en = 1'b1;
        go_to(8'h05);
        en = 1'b0; blank_lz = 1'b1;
        wait_seg1(2'b10);
        chk("q_d0_5", 32'(q1), 32'h6D);
        wait_seg1(2'b01);
        chk("q_blank", 32'(q1), 32'h00);
        blank_lz = 1'b0;
        #1 chk("q_noblank", 32'(q1), 32'h3F);
        clr = 1'b1;
        @(negedge clk_sys);
        clr = 1'b0; blank_lz = 1'b1;
        wait_seg1(2'b10);
        chk("q_zero_d0", 32'(q1), 32'h3F);
        wait_seg1(2'b01);
        chk("q_zero_d1", 32'(q1), 32'h00);

        clr = 1'b1;
        @(negedge clk_sys);
        clr = 1'b0; en = 1'b1; up_dn = 1'b1;
        repeat (99) @(negedge clk_sys);
        chk("d2_099", 32'(bcd2), 32'h099);
        @(negedge clk_sys);
        chk("d2_100", 32'(bcd2), 32'h100);
        chk("d2_100_carry", 32'(carry2), 32'h0);
        repeat (899) @(negedge clk_sys);
        chk("d2_999", 32'(bcd2), 32'h999);
        @(negedge clk_sys);
        chk("d2_wrap", 32'(bcd2), 32'h000);
        chk("d2_wrap_carry", 32'(carry2), 32'h1);
        @(negedge clk_sys);
        chk("d2_001", 32'(bcd2), 32'h001);
        chk("d2_carry_end", 32'(carry2), 32'h0);

        n = 0;
        while (seg2 !== 3'b110 && n < 10) begin @(negedge clk_sys); n++; end
        chk("scan3_110", 32'(seg2), 32'h6);
        @(negedge clk_sys);
        chk("scan3_101", 32'(seg2), 32'h5);
        @(negedge clk_sys);
        chk("scan3_011", 32'(seg2), 32'h3);
        @(negedge clk_sys);
        chk("scan3_wrap", 32'(seg2), 32'h6);

        repeat (4000) begin
            @(negedge clk_sys);
            en       = $urandom_range(0, 3) != 0;
            up_dn    = $urandom_range(0, 1) == 1;
            clr      = $urandom_range(0, 63) == 0;
            blank_lz = $urandom_range(0, 1) == 1;
        end
        @(negedge clk_sys);
        en = 1'b0; clr = 1'b0;
        repeat (4) @(negedge clk_sys);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
